sdram_read_arbiter: RTL

- Shares the single Avalon-bridge read port (SDRAM, 16-bit words, 25-bit word address) between the I2S audio fetcher and the video fetcher.
- Uses round-robin arbitration with audio preference when idle, so neither requester starves.
- A watchdog completes any read the bridge never acknowledges, so a requester cannot hang.
- Sits between the two fetch engines and the bridge master.

---
 rtl/sdram_read_arbiter.sv | 82 ++++++++
 1 files changed

// File: rtl/sdram_read_arbiter.sv
// sdram_read_arbiter: round-robin audio/video arbiter for the SDRAM bridge read port, with a watchdog that completes unacknowledged reads
module sdram_read_arbiter #(
    parameter int ADDR_W         = 25,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic [ADDR_W-1:0] aud_addr,
    input  logic              aud_rden,
    output logic [DATA_W-1:0] aud_rddata,
    output logic              aud_ack,
    input  logic [ADDR_W-1:0] vid_addr,
    input  logic              vid_rden,
    output logic [DATA_W-1:0] vid_rddata,
    output logic              vid_ack,
    output logic [ADDR_W-1:0] bridge_addr,
    output logic              bridge_read,
    input  logic [DATA_W-1:0] bridge_readdata,
    input  logic              bridge_ack,
    input  logic              timeout_clear,
    output logic              timeout_flag,
    output logic              grant_vid
);
    typedef enum logic [1:0] {IDLE, BUSY, FAULT, RELEASE} state_t;
    localparam logic [11:0] LAST = 12'(TIMEOUT_CYCLES - 1);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       cnt_q, cnt_d;
    logic              gvid_q, gvid_d, flag_q, flag_d, ack;
    logic [DATA_W-1:0] data;
    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            gvid_q  <= 1'b1;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            gvid_q  <= gvid_d;
            flag_q  <= flag_d;
        end
    end
    // A fault and a clear landing together leave the flag set
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        gvid_d  = gvid_q;
        flag_d  = (state_q == FAULT) | (flag_q & ~timeout_clear);
        case (state_q)
            IDLE: if (aud_rden | vid_rden) begin
                gvid_d  = vid_rden & (~aud_rden | ~gvid_q);
                addr_d  = gvid_d ? vid_addr : aud_addr;
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = bridge_ack ? RELEASE : (cnt_q == LAST) ? FAULT : BUSY;
            end
            FAULT:   state_d = RELEASE;
            RELEASE: state_d = (!bridge_ack && !(gvid_q ? vid_rden : aud_rden)) ? IDLE : RELEASE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        ack          = (state_q == BUSY && bridge_ack) || state_q == FAULT;
        data         = (state_q == BUSY) ? bridge_readdata : '0;
        aud_ack      = ack & ~gvid_q;
        vid_ack      = ack & gvid_q;
        aud_rddata   = aud_ack ? data : '0;
        vid_rddata   = vid_ack ? data : '0;
        bridge_read  = state_q == BUSY;
        bridge_addr  = addr_q;
        timeout_flag = flag_q;
        grant_vid    = gvid_q;
    end
endmodule
